// File: rtl/t05_writeback_scoreboard.sv
// Write-port front end of the 32x32 register file: merges ALU and load completions
// through a 1-entry ALU skid buffer and tracks per-register busy bits to stall hazardous issues.
module t05_writeback_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int MAX_LOADS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  input  logic              issue_uses_rs1,
  input  logic              issue_uses_rs2,
  input  logic              issue_is_load,
  output logic              issue_stall,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wb_write,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       busy_o,
  output logic              err
);

  localparam int CNT_W = 3;

  // Handshake: an ALU result transfers on a cycle with alu_valid && alu_ready; the
  // producer holds alu_rd/alu_data stable while alu_valid && !alu_ready. Load data has
  // no back-pressure and is consumed on every cycle mem_valid is high.

  logic [31:0]       busy, busy_next;
  logic [CNT_W-1:0]  load_cnt, load_cnt_next;
  logic              skid_full;
  logic [4:0]        skid_rd;
  logic [DATA_W-1:0] skid_data;

  logic              accept, load_inc, load_dec;
  logic              alu_take, alu_live, mem_live;
  logic              sel_valid, skid_load, skid_drain, err_set;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign busy_o    = busy;
  assign alu_ready = !skid_full;

  always_comb begin
    issue_stall = issue_valid && (
                    (issue_uses_rs1 && busy[issue_rs1]) ||
                    (issue_uses_rs2 && busy[issue_rs2]) ||
                    ((issue_rd != 5'd0) && busy[issue_rd]) ||
                    (issue_is_load && (load_cnt == CNT_W'(MAX_LOADS))));
    accept   = issue_valid && !issue_stall;
    load_inc = accept && issue_is_load;
    load_dec = mem_valid && (load_cnt != '0);
  end

  // Completions to x0 are consumed but never compete for the port or the skid.
  always_comb begin
    alu_take   = alu_valid && !skid_full;
    alu_live   = alu_take && (alu_rd != 5'd0);
    mem_live   = mem_valid && (mem_rd != 5'd0);
    sel_valid  = 1'b0;
    sel_rd     = alu_rd;
    sel_data   = alu_data;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (mem_live) begin
      sel_valid = 1'b1;
      sel_rd    = mem_rd;
      sel_data  = mem_data;
      skid_load = alu_live;
    end else if (skid_full) begin
      sel_valid  = 1'b1;
      sel_rd     = skid_rd;
      sel_data   = skid_data;
      skid_drain = 1'b1;
    end else if (alu_live) begin
      sel_valid = 1'b1;
    end
  end

  always_comb begin
    err_set = (mem_valid && (load_cnt == '0)) ||
              (mem_live && !busy[mem_rd]) ||
              (alu_live && !busy[alu_rd]);
    busy_next = busy;
    if (wb_write) busy_next[wb_rd] = 1'b0;
    if (accept && (issue_rd != 5'd0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
    load_cnt_next = load_cnt;
    if (load_inc && !load_dec) load_cnt_next = load_cnt + CNT_W'(1);
    else if (!load_inc && load_dec) load_cnt_next = load_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      load_cnt  <= '0;
      skid_full <= 1'b0;
      skid_rd   <= '0;
      skid_data <= '0;
      wb_write  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      busy     <= busy_next;
      load_cnt <= load_cnt_next;
      if (skid_load) begin
        skid_full <= 1'b1;
        skid_rd   <= alu_rd;
        skid_data <= alu_data;
      end else if (skid_drain) begin
        skid_full <= 1'b0;
      end
      wb_write <= sel_valid;
      if (sel_valid) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
      end
      if (err_set) err <= 1'b1;
    end
  end

endmodule
